mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// -----------------------------------------------------------------------------
// mc_sequencer
//
// Control sequencer for a multi-cycle RV32 datapath. It walks each instruction
// through FETCH -> DECODE -> (execute / address / memory / branch / jump)
// and drives the datapath enables and multiplexer selects for every step.
//
// Ports
//   clk             in   rising-edge clock
//   clr_n           in   asynchronous active-low reset
//   opcode[6:0]     in   instruction bits [6:0], valid from DECODE onward
//   func3[2:0]      in   instruction bits [14:12]
//   compare[2:0]    in   ALU flags {eq, lt, ltu} for rs1 vs rs2
//   mem_ready       in   memory completes the current access this cycle
//   PCWrite         out  load PC
//   IorD            out  memory address source: 0=PC, 1=ALUOut
//   MemoryWrite     out  memory write strobe
//   MemoryRead      out  memory read strobe
//   IRWrite         out  load instruction register
//   ALUOutRegWrite  out  load ALUOut register
//   Regwrite        out  register-file write enable
//   S_rs1           out  ALU A: 0=PC (OldPC in DECODE/JAL), 1=rs1
//   S_rs2[1:0]      out  ALU B: 00=rs2, 01=constant 4, 10=immediate
//   S_func3         out  1=ALU op from func3, 0=add
//   S_PC            out  PC source: 0=ALU result, 1=ALUOut
//   S_wb[1:0]       out  writeback source: 00=ALUOut, 01=memory data, 10=PC
//   instr_done      out  one-cycle pulse on the last cycle of an instruction
//   trap            out  sticky illegal-instruction flag
//   state_dbg[3:0]  out  current state encoding
//
// Memory handshake: the sequencer holds MemoryRead or MemoryWrite (with IorD)
// steady for as long as it sits in FETCH, MEM_RD or MEM_WR; the access
// completes in the first cycle that samples mem_ready=1 at the rising edge,
// and the sequencer leaves the state on that same edge. There is no
// back-pressure from the sequencer side, so mem_ready is a one-sided
// completion strobe rather than a valid/ready pair.
// -----------------------------------------------------------------------------
module mc_sequencer (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [2:0] compare,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemoryWrite,
    output logic       MemoryRead,
    output logic       IRWrite,
    output logic       ALUOutRegWrite,
    output logic       Regwrite,
    output logic       S_rs1,
    output logic [1:0] S_rs2,
    output logic       S_func3,
    output logic       S_PC,
    output logic [1:0] S_wb,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WB = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_JAL    = 4'd9,
        S_WB_ALU = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t r_state;
    state_t w_next;
    logic   r_trap;

    logic   w_eq;
    logic   w_lt;
    logic   w_ltu;
    logic   w_br_legal;
    logic   w_br_taken;

    assign w_eq  = compare[2];
    assign w_lt  = compare[1];
    assign w_ltu = compare[0];

    // Branch condition. func3[0] inverts the base comparison; 010/011 are
    // not branch encodings and send the sequencer to TRAP.
    always_comb begin
        w_br_legal = 1'b1;
        w_br_taken = 1'b0;
        case (func3)
            3'b000:  w_br_taken = w_eq;
            3'b001:  w_br_taken = ~w_eq;
            3'b100:  w_br_taken = w_lt;
            3'b101:  w_br_taken = ~w_lt;
            3'b110:  w_br_taken = w_ltu;
            3'b111:  w_br_taken = ~w_ltu;
            default: w_br_legal = 1'b0;
        endcase
    end

    // State register. Asynchronous clear puts the sequencer straight back
    // into FETCH so a half-finished instruction never reaches writeback.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky trap flag: set on the edge that enters TRAP, cleared only by reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_trap <= 1'b0;
        end else if (w_next == S_TRAP) begin
            r_trap <= 1'b1;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next         = r_state;
        PCWrite        = 1'b0;
        IorD           = 1'b0;
        MemoryWrite    = 1'b0;
        MemoryRead     = 1'b0;
        IRWrite        = 1'b0;
        ALUOutRegWrite = 1'b0;
        Regwrite       = 1'b0;
        S_rs1          = 1'b0;
        S_rs2          = 2'b00;
        S_func3        = 1'b0;
        S_PC           = 1'b0;
        S_wb           = 2'b00;
        instr_done     = 1'b0;

        case (r_state)
            S_FETCH: begin
                MemoryRead = 1'b1;
                IorD       = 1'b0;
                if (mem_ready) begin
                    // Latch the instruction and advance PC by 4 in one go.
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    S_rs1   = 1'b0;
                    S_rs2   = 2'b01;
                    S_PC    = 1'b0;
                    w_next  = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculatively compute OldPC + imm into ALUOut so BRANCH
                // and JAL can use it as their target.
                S_rs1          = 1'b0;
                S_rs2          = 2'b10;
                ALUOutRegWrite = 1'b1;
                case (opcode)
                    OP_R:     w_next = S_EXEC_R;
                    OP_I:     w_next = S_EXEC_I;
                    OP_LOAD:  w_next = S_ADDR;
                    OP_STORE: w_next = S_ADDR;
                    OP_BR:    w_next = S_BRANCH;
                    OP_JAL:   w_next = S_JAL;
                    default:  w_next = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                S_rs1          = 1'b1;
                S_rs2          = 2'b00;
                S_func3        = 1'b1;
                ALUOutRegWrite = 1'b1;
                w_next         = S_WB_ALU;
            end

            S_EXEC_I: begin
                S_rs1          = 1'b1;
                S_rs2          = 2'b10;
                S_func3        = 1'b1;
                ALUOutRegWrite = 1'b1;
                w_next         = S_WB_ALU;
            end

            S_WB_ALU: begin
                Regwrite   = 1'b1;
                S_wb       = 2'b00;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_ADDR: begin
                S_rs1          = 1'b1;
                S_rs2          = 2'b10;
                S_func3        = 1'b0;
                ALUOutRegWrite = 1'b1;
                w_next         = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                MemoryRead = 1'b1;
                IorD       = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                Regwrite   = 1'b1;
                S_wb       = 2'b01;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_MEM_WR: begin
                MemoryWrite = 1'b1;
                IorD        = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
            end

            S_BRANCH: begin
                S_rs1 = 1'b1;
                S_rs2 = 2'b00;
                S_PC  = 1'b1;
                if (w_br_legal) begin
                    PCWrite    = w_br_taken;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_TRAP;
                end
            end

            S_JAL: begin
                // PC already holds OldPC+4 (the link value); ALUOut holds the
                // target computed in DECODE.
                Regwrite   = 1'b1;
                S_wb       = 2'b10;
                PCWrite    = 1'b1;
                S_PC       = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_TRAP: begin
                w_next = S_TRAP;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase

        // While clear is held every enable is forced low at once, even though
        // the state register already reads FETCH (which would otherwise
        // request a memory read).
        if (!clr_n) begin
            PCWrite        = 1'b0;
            IorD           = 1'b0;
            MemoryWrite    = 1'b0;
            MemoryRead     = 1'b0;
            IRWrite        = 1'b0;
            ALUOutRegWrite = 1'b0;
            Regwrite       = 1'b0;
            S_rs1          = 1'b0;
            S_rs2          = 2'b00;
            S_func3        = 1'b0;
            S_PC           = 1'b0;
            S_wb           = 2'b00;
            instr_done     = 1'b0;
        end
    end

    assign trap      = r_trap;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_mc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_sequencer
//
// Directed bench for mc_sequencer. Each driven cycle pushes a hand-written
// expected output word (state plus every control output) into a queue; a
// monitor on the falling edge pops one word per cycle and compares it with
// the DUT outputs.
//
// Expected word layout:
//   [19:16] state_dbg  [15] PCWrite  [14] IorD  [13] MemoryWrite
//   [12] MemoryRead    [11] IRWrite  [10] ALUOutRegWrite  [9] Regwrite
//   [8] S_rs1  [7:6] S_rs2  [5] S_func3  [4] S_PC  [3:2] S_wb
//   [1] instr_done  [0] trap
// -----------------------------------------------------------------------------
module tb_mc_sequencer;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       clr_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [2:0] compare;
    logic       mem_ready;

    logic       PCWrite, IorD, MemoryWrite, MemoryRead, IRWrite;
    logic       ALUOutRegWrite, Regwrite, S_rs1, S_func3, S_PC;
    logic [1:0] S_rs2, S_wb;
    logic       instr_done, trap;
    logic [3:0] state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_sequencer dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .opcode         (opcode),
        .func3          (func3),
        .compare        (compare),
        .mem_ready      (mem_ready),
        .PCWrite        (PCWrite),
        .IorD           (IorD),
        .MemoryWrite    (MemoryWrite),
        .MemoryRead     (MemoryRead),
        .IRWrite        (IRWrite),
        .ALUOutRegWrite (ALUOutRegWrite),
        .Regwrite       (Regwrite),
        .S_rs1          (S_rs1),
        .S_rs2          (S_rs2),
        .S_func3        (S_func3),
        .S_PC           (S_PC),
        .S_wb           (S_wb),
        .instr_done     (instr_done),
        .trap           (trap),
        .state_dbg      (state_dbg)
    );

    // ---------------- expected-word constants ----------------
    localparam logic [19:0] ST_FETCH = 20'h00000;
    localparam logic [19:0] ST_DEC   = 20'h10000;
    localparam logic [19:0] ST_EXR   = 20'h20000;
    localparam logic [19:0] ST_EXI   = 20'h30000;
    localparam logic [19:0] ST_ADDR  = 20'h40000;
    localparam logic [19:0] ST_MRD   = 20'h50000;
    localparam logic [19:0] ST_MWB   = 20'h60000;
    localparam logic [19:0] ST_MWR   = 20'h70000;
    localparam logic [19:0] ST_BR    = 20'h80000;
    localparam logic [19:0] ST_JAL   = 20'h90000;
    localparam logic [19:0] ST_WB    = 20'hA0000;
    localparam logic [19:0] ST_TRAP  = 20'hB0000;

    localparam logic [19:0] PCW     = 20'h08000;
    localparam logic [19:0] IORD    = 20'h04000;
    localparam logic [19:0] MWR     = 20'h02000;
    localparam logic [19:0] MRD     = 20'h01000;
    localparam logic [19:0] IRW     = 20'h00800;
    localparam logic [19:0] AOW     = 20'h00400;
    localparam logic [19:0] RW      = 20'h00200;
    localparam logic [19:0] RS1     = 20'h00100;
    localparam logic [19:0] RS2_IMM = 20'h00080;
    localparam logic [19:0] RS2_4   = 20'h00040;
    localparam logic [19:0] F3      = 20'h00020;
    localparam logic [19:0] SPC     = 20'h00010;
    localparam logic [19:0] WB_PC   = 20'h00008;
    localparam logic [19:0] WB_MEM  = 20'h00004;
    localparam logic [19:0] DONE    = 20'h00002;
    localparam logic [19:0] TRP     = 20'h00001;

    localparam logic [19:0] E_RESET    = 20'h00000;
    localparam logic [19:0] E_FETCH_OK = ST_FETCH | MRD | IRW | PCW | RS2_4;
    localparam logic [19:0] E_FETCH_WT = ST_FETCH | MRD;
    localparam logic [19:0] E_DEC      = ST_DEC | RS2_IMM | AOW;
    localparam logic [19:0] E_EXR      = ST_EXR | RS1 | F3 | AOW;
    localparam logic [19:0] E_EXI      = ST_EXI | RS1 | RS2_IMM | F3 | AOW;
    localparam logic [19:0] E_WB       = ST_WB | RW | DONE;
    localparam logic [19:0] E_ADDR     = ST_ADDR | RS1 | RS2_IMM | AOW;
    localparam logic [19:0] E_MRD      = ST_MRD | MRD | IORD;
    localparam logic [19:0] E_MWB      = ST_MWB | RW | WB_MEM | DONE;
    localparam logic [19:0] E_MWR_WT   = ST_MWR | MWR | IORD;
    localparam logic [19:0] E_MWR_OK   = ST_MWR | MWR | IORD | DONE;
    localparam logic [19:0] E_BR_NT    = ST_BR | RS1 | SPC | DONE;
    localparam logic [19:0] E_BR_T     = ST_BR | RS1 | SPC | DONE | PCW;
    localparam logic [19:0] E_BR_ILL   = ST_BR | RS1 | SPC;
    localparam logic [19:0] E_JAL      = ST_JAL | RW | WB_PC | PCW | SPC | DONE;
    localparam logic [19:0] E_TRAP     = ST_TRAP | TRP;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [19:0] mon_exp;
    logic [19:0] mon_got;
    string       mon_name;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {state_dbg, PCWrite, IorD, MemoryWrite, MemoryRead,
                        IRWrite, ALUOutRegWrite, Regwrite, S_rs1, S_rs2,
                        S_func3, S_PC, S_wb, instr_done, trap};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h (t=%0t)",
                         mon_name, mon_got, mon_exp, $time);
            end
            n_checks++;
            if (MemoryRead && MemoryWrite) begin
                n_fail++;
                $display("FAIL %s_mem_excl: got rd=%b wr=%b expected not both 1",
                         mon_name, MemoryRead, MemoryWrite);
            end
        end
    end

    // ---------------- driver ----------------
    // Drive one cycle's inputs just after the rising edge, record the
    // expected outputs for that cycle, then advance to the next edge.
    task automatic cyc(input string nm, input logic clr, input logic [6:0] op,
                       input logic [2:0] f3, input logic [2:0] cmp,
                       input logic mr, input logic [19:0] e);
        clr_n     = clr;
        opcode    = op;
        func3     = f3;
        compare   = cmp;
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string nm, input logic [6:0] op, input logic [19:0] e_exec);
        cyc({nm, "_fetch"}, 1'b1, op, 3'b000, 3'b000, 1'b1, E_FETCH_OK);
        cyc({nm, "_dec"},   1'b1, op, 3'b000, 3'b000, 1'b1, E_DEC);
        cyc({nm, "_exec"},  1'b1, op, 3'b000, 3'b000, 1'b1, e_exec);
        cyc({nm, "_wb"},    1'b1, op, 3'b000, 3'b000, 1'b1, E_WB);
    endtask

    task automatic run_branch(input string nm, input logic [2:0] f3,
                              input logic [2:0] cmp, input logic [19:0] e_br);
        cyc({nm, "_fetch"}, 1'b1, OP_BR, f3, cmp, 1'b1, E_FETCH_OK);
        cyc({nm, "_dec"},   1'b1, OP_BR, f3, cmp, 1'b1, E_DEC);
        cyc({nm, "_br"},    1'b1, OP_BR, f3, cmp, 1'b1, e_br);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr_n     = 1'b0;
        opcode    = 7'd0;
        func3     = 3'd0;
        compare   = 3'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Held in reset: every output low, state FETCH.
        cyc("reset", 1'b0, OP_R, 3'b000, 3'b000, 1'b1, E_RESET);

        // R-type add: states 0,1,2,10.
        run_alu("radd", OP_R, E_EXR);
        // I-type.
        run_alu("iadd", OP_I, E_EXI);

        // Load, one FETCH wait then three MEM_RD waits.
        cyc("ld_fetch_wait", 1'b1, OP_LOAD, 3'b010, 3'b000, 1'b0, E_FETCH_WT);
        cyc("ld_fetch",      1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_FETCH_OK);
        cyc("ld_dec",        1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_DEC);
        cyc("ld_addr",       1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_ADDR);
        for (int i = 0; i < 3; i++)
            cyc("ld_mrd_wait", 1'b1, OP_LOAD, 3'b010, 3'b000, 1'b0, E_MRD);
        cyc("ld_mrd",        1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_MRD);
        cyc("ld_mwb",        1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_MWB);

        // Store with one write wait.
        cyc("st_fetch",    1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_FETCH_OK);
        cyc("st_dec",      1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_DEC);
        cyc("st_addr",     1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_ADDR);
        cyc("st_mwr_wait", 1'b1, OP_STORE, 3'b010, 3'b000, 1'b0, E_MWR_WT);
        cyc("st_mwr",      1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_MWR_OK);

        // Branches: compare = {eq, lt, ltu}.
        run_branch("bne_eq",   3'b001, 3'b100, E_BR_NT);
        run_branch("bne_ne",   3'b001, 3'b000, E_BR_T);
        run_branch("beq_eq",   3'b000, 3'b100, E_BR_T);
        run_branch("blt_ge",   3'b100, 3'b001, E_BR_NT);
        run_branch("bge_lt",   3'b101, 3'b010, E_BR_NT);
        run_branch("bltu_lt",  3'b110, 3'b001, E_BR_T);
        run_branch("bgeu_ge",  3'b111, 3'b000, E_BR_T);

        // JAL.
        cyc("jal_fetch", 1'b1, OP_JAL, 3'b000, 3'b000, 1'b1, E_FETCH_OK);
        cyc("jal_dec",   1'b1, OP_JAL, 3'b000, 3'b000, 1'b1, E_DEC);
        cyc("jal_exec",  1'b1, OP_JAL, 3'b000, 3'b000, 1'b1, E_JAL);

        // Illegal opcode: TRAP from cycle 3, held for 20 cycles.
        cyc("bad_fetch", 1'b1, OP_BAD, 3'b000, 3'b000, 1'b1, E_FETCH_OK);
        cyc("bad_dec",   1'b1, OP_BAD, 3'b000, 3'b000, 1'b1, E_DEC);
        for (int i = 0; i < 20; i++)
            cyc("bad_trap", 1'b1, OP_BAD, 3'b000, 3'b111, 1'b1, E_TRAP);
        cyc("bad_clr", 1'b0, OP_BAD, 3'b000, 3'b000, 1'b1, E_RESET);
        run_alu("post_trap", OP_R, E_EXR);

        // Branch with reserved func3 010 traps without PCWrite or done.
        run_branch("br_ill", 3'b010, 3'b100, E_BR_ILL);
        cyc("br_ill_trap0", 1'b1, OP_BR, 3'b010, 3'b100, 1'b1, E_TRAP);
        cyc("br_ill_trap1", 1'b1, OP_BR, 3'b010, 3'b100, 1'b1, E_TRAP);
        cyc("br_ill_clr",   1'b0, OP_BR, 3'b010, 3'b100, 1'b1, E_RESET);

        // Store interrupted by clear mid-write, with mem_ready pending.
        cyc("sti_fetch",    1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_FETCH_OK);
        cyc("sti_dec",      1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_DEC);
        cyc("sti_addr",     1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_ADDR);
        cyc("sti_mwr_wait", 1'b1, OP_STORE, 3'b010, 3'b000, 1'b0, E_MWR_WT);
        cyc("sti_clr",      1'b0, OP_STORE, 3'b010, 3'b000, 1'b1, E_RESET);

        // First instruction after the clear runs normally.
        run_alu("post_clr", OP_R, E_EXR);

        // Let the monitor take the last word, then confirm nothing is left.
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
